// File: rtl/ysyx_25030093_mem_pkg.sv
// ysyx_25030093_mem_pkg: shared FSM state, response codes, LFSR taps and the paddr_read memory hook
package ysyx_25030093_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  logic [31:0] sim_mem [0:63];
  int paddr_read_calls;
  // Word-sized memory hook standing in for the host-side paddr_read; counts every call
  function automatic logic [31:0] paddr_read(input logic [31:0] raddr, input int len);
    logic [31:0] off;
    off = raddr - MEM_BASE;
    paddr_read_calls = paddr_read_calls + 1;
    return (len == 4 && off[31:8] == '0 && off[1:0] == 2'b00) ? sim_mem[off[7:2]] : 32'h0;
  endfunction
  // Loader used to fill the memory image before fetching
  function automatic void paddr_write(input logic [31:0] waddr, input logic [31:0] wdata);
    logic [31:0] off;
    off = waddr - MEM_BASE;
    if (off[31:8] == '0 && off[1:0] == 2'b00) sim_mem[off[7:2]] = wdata;
  endfunction
endpackage

// File: rtl/ysyx_25030093_lfsr.sv
// ysyx_25030093_lfsr: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded on reset
module ysyx_25030093_lfsr
  import ysyx_25030093_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  logic [7:0] q_q, q_d;
  // Shift left, feeding the parity of the tapped bits into bit 0
  always_comb q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  // Load the seed in reset, advance every cycle otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= seed;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/ysyx_25030093_isram.sv
// ysyx_25030093_isram: AXI-lite style instruction SRAM responder with fixed or random (YSYX_25030093_ISRAM_RAND_DELAY_EN) latency
module ysyx_25030093_isram
  import ysyx_25030093_mem_pkg::*;
#(
  parameter int         LATENCY   = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q;
  logic [3:0]  lat;
  logic        accept, aligned;
`ifdef YSYX_25030093_ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       unused_lat;
  ysyx_25030093_lfsr u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .q(lfsr));
  assign lat = {1'b0, lfsr[2:0]} + 4'd1;
  assign unused_lat = ^{lfsr[7:3], 4'(LATENCY)};
`else
  logic unused_seed;
  assign lat = 4'(LATENCY);
  assign unused_seed = ^LFSR_SEED;
`endif
  assign accept  = arvalid && arready_q;
  assign aligned = araddr[1:0] == 2'b00;
  // State register: reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  // Next state: L==1 jumps to RESP; otherwise WAIT counts L-2 down to 0 then one more edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (lat <= 4'd1) ? RESP : WAIT;
        cnt_d   = (lat <= 4'd1) ? 4'd0 : lat - 4'd2;
      end
      WAIT: begin
        state_d = (cnt_q == 4'd0) ? RESP : WAIT;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      RESP: if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they change only on clock edges
  always_comb begin
    arready_d = state_d == IDLE;
    rvalid_d  = state_d == RESP;
    rresp_d   = accept ? (aligned ? RESP_OKAY : RESP_SLVERR) : rresp_q;
  end
  // Read port: one memory call per aligned accept, zero data for misaligned fetches
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= 32'h0;
    else if (accept && aligned) rdata_q <= paddr_read(araddr, 4);
    else if (accept) rdata_q <= 32'h0;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
endmodule
